// File: rtl/sar_pkg.sv
// Shared types and default parameters for the SAR ADC controller.
package sar_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SAMPLE,
    S_CONVERT,
    S_DONE
  } state_t;

  localparam int DEF_WIDTH         = 12;
  localparam int DEF_SAMPLE_CYCLES = 2;
  localparam int DEF_SETTLE_CYCLES = 1;

endpackage

// File: rtl/sar_shift_core.sv
// Successive-approximation datapath: one-hot trial mask, kept bits, bit decision.
module sar_shift_core #(
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic             cmp,
  input  logic             drive,
  output logic [WIDTH-1:0] dac_code,
  output logic [WIDTH-1:0] decided,
  output logic             last
);

  logic [WIDTH-1:0] mask;
  logic [WIDTH-1:0] kept;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mask <= '0;
      kept <= '0;
    end else if (load) begin
      mask <= {1'b1, {(WIDTH-1){1'b0}}};
      kept <= '0;
    end else if (step) begin
      mask <= mask >> 1;
      if (cmp) kept <= kept | mask;
    end
  end

  // Code including the decision on the bit currently under trial.
  assign decided  = cmp ? (kept | mask) : kept;
  assign last     = mask[0];
  // Once the mask has shifted out, kept|mask is the final code.
  assign dac_code = drive ? (kept | mask) : '0;

endmodule

// File: rtl/sar_adc_ctrl.sv
// SAR ADC controller: FSM, sample/settle timing, channel select and result capture.
module sar_adc_ctrl
  import sar_pkg::*;
#(
  parameter int WIDTH         = DEF_WIDTH,
  parameter int NUM_CH        = 4,
  parameter int SAMPLE_CYCLES = DEF_SAMPLE_CYCLES,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CH_W-1:0]  ch_sel,
  input  logic             scan_en,
  input  logic             cmp,
  output logic [CH_W-1:0]  mux_sel,
  output logic             sample,
  output logic [WIDTH-1:0] dac_code,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [CH_W-1:0]  result_ch
);

  localparam int CNT_MAX = (SAMPLE_CYCLES > SETTLE_CYCLES) ? SAMPLE_CYCLES : SETTLE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CH_W-1:0]  ch;
  logic             sample_end, settle_end, last;
  logic [WIDTH-1:0] decided;

  assign sample_end = (state == S_SAMPLE)  && (cnt == CNT_W'(SAMPLE_CYCLES - 1));
  assign settle_end = (state == S_CONVERT) && (cnt == CNT_W'(SETTLE_CYCLES - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    sample    = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE:    if (start) state_nxt = S_SAMPLE;
      S_SAMPLE: begin
        sample = 1'b1;
        busy   = 1'b1;
        if (sample_end) state_nxt = S_CONVERT;
      end
      S_CONVERT: begin
        busy = 1'b1;
        if (settle_end && last) state_nxt = S_DONE;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = scan_en ? S_SAMPLE : S_IDLE;
      end
      default:   state_nxt = S_IDLE;
    endcase
  end

  // One counter serves both the acquire window and each trial's settle window.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                        cnt <= '0;
    else if (state == S_SAMPLE || state == S_CONVERT)  cnt <= (sample_end || settle_end) ? '0 : cnt + 1'b1;
    else                                               cnt <= '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ch <= '0;
    end else if (state == S_IDLE && start) begin
      ch <= ({1'b0, ch_sel} < (CH_W+1)'(NUM_CH)) ? ch_sel : '0;
    end else if (state == S_DONE && scan_en) begin
      ch <= (ch == CH_W'(NUM_CH - 1)) ? '0 : ch + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      result    <= '0;
      result_ch <= '0;
    end else if (settle_end && last) begin
      result    <= decided;
      result_ch <= ch;
    end
  end

  assign mux_sel = ch;

  sar_shift_core #(.WIDTH(WIDTH)) u_core (
    .clk      (clk),
    .reset    (reset),
    .load     (sample_end),
    .step     (settle_end),
    .cmp      (cmp),
    .drive    (state == S_CONVERT || state == S_DONE),
    .dac_code (dac_code),
    .decided  (decided),
    .last     (last)
  );

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// Bench for sar_adc_ctrl: three parameterisations driven by an ideal comparator model.
module tb_sar_adc_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        start_v[3];
  logic        scan_v[3];
  logic [1:0]  chs_v[3];
  int          cmode[3];   // 0: cmp stuck 0, 1: cmp stuck 1, 2: cmp = vin >= dac_code
  logic [15:0] vin[3];

  logic [15:0] dac_v[3], res_v[3];
  logic [1:0]  mux_v[3], rc_v[3];
  logic        smp_v[3], busy_v[3], done_v[3];
  logic [11:0] dac0, res0, dac1, res1;
  logic [7:0]  dac2, res2;
  logic        cmp0, cmp1, cmp2;

  logic [15:0] prev_res[3];
  int          prev_ch[3];
  int          n_chk = 0;
  int          n_fail = 0;

  assign cmp0 = (cmode[0] == 2) ? ({4'h0, dac0} <= vin[0]) : cmode[0][0];
  assign cmp1 = (cmode[1] == 2) ? ({4'h0, dac1} <= vin[1]) : cmode[1][0];
  assign cmp2 = (cmode[2] == 2) ? ({8'h0, dac2} <= vin[2]) : cmode[2][0];
  assign dac_v[0] = {4'h0, dac0};
  assign dac_v[1] = {4'h0, dac1};
  assign dac_v[2] = {8'h0, dac2};
  assign res_v[0] = {4'h0, res0};
  assign res_v[1] = {4'h0, res1};
  assign res_v[2] = {8'h0, res2};

  sar_adc_ctrl #(.WIDTH(12), .NUM_CH(4), .SAMPLE_CYCLES(2), .SETTLE_CYCLES(1)) dut0 (
    .clk(clk), .reset(reset), .start(start_v[0]), .ch_sel(chs_v[0]), .scan_en(scan_v[0]),
    .cmp(cmp0), .mux_sel(mux_v[0]), .sample(smp_v[0]), .dac_code(dac0), .busy(busy_v[0]),
    .done(done_v[0]), .result(res0), .result_ch(rc_v[0]));

  sar_adc_ctrl #(.WIDTH(12), .NUM_CH(3), .SAMPLE_CYCLES(2), .SETTLE_CYCLES(3)) dut1 (
    .clk(clk), .reset(reset), .start(start_v[1]), .ch_sel(chs_v[1]), .scan_en(scan_v[1]),
    .cmp(cmp1), .mux_sel(mux_v[1]), .sample(smp_v[1]), .dac_code(dac1), .busy(busy_v[1]),
    .done(done_v[1]), .result(res1), .result_ch(rc_v[1]));

  sar_adc_ctrl #(.WIDTH(8), .NUM_CH(4), .SAMPLE_CYCLES(2), .SETTLE_CYCLES(1)) dut2 (
    .clk(clk), .reset(reset), .start(start_v[2]), .ch_sel(chs_v[2]), .scan_en(scan_v[2]),
    .cmp(cmp2), .mux_sel(mux_v[2]), .sample(smp_v[2]), .dac_code(dac2), .busy(busy_v[2]),
    .done(done_v[2]), .result(res2), .result_ch(rc_v[2]));

  function automatic int wid(input int d);
    return (d == 2) ? 8 : 12;
  endfunction
  function automatic int settle(input int d);
    return (d == 1) ? 3 : 1;
  endfunction
  function automatic int nch(input int d);
    return (d == 1) ? 3 : 4;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_conv(input int d, input int ch);
    chs_v[d]   = 2'(ch);
    start_v[d] = 1'b1;
    tick();
    start_v[d] = 1'b0;
  endtask

  // Walks one conversion from cycle 1 to its DONE cycle, comparing every cycle
  // against a binary-search model of an ideal SAR.
  task automatic walk_conv(input int d, input int ch, input int drop_at, input bit poke);
    int w, s, t;
    logic [15:0] trace[16];
    logic [15:0] kept, trial, expres, ed, er;
    bit cm, es, eb, edn;
    int erc;
    w = wid(d); s = settle(d); t = 2 + w * s + 1;
    kept = '0;
    for (int i = w - 1; i >= 0; i--) begin
      trial = kept | (16'(1) << i);
      cm = (cmode[d] == 2) ? (vin[d] >= trial) : cmode[d][0];
      if (cm) kept = trial;
      trace[w-1-i] = trial;
    end
    expres = (cmode[d] == 1) ? 16'((1 << w) - 1) : (cmode[d] == 0) ? 16'h0 : vin[d];
    if (poke) begin
      start_v[d] = 1'b1;
      chs_v[d]   = 2'(ch + 1);
    end
    for (int c = 1; c <= t; c++) begin
      if (c == drop_at) scan_v[d] = 1'b0;
      es  = (c <= 2);
      eb  = (c < t);
      edn = (c == t);
      ed  = (c <= 2) ? 16'h0 : (c < t) ? trace[(c-3)/s] : expres;
      n_chk++;
      if (dac_v[d] !== ed || smp_v[d] !== es || busy_v[d] !== eb || done_v[d] !== edn || mux_v[d] !== 2'(ch)) begin
        n_fail++;
        $display("FAIL conv dut%0d cyc%0d: dac=%h sample=%b busy=%b done=%b mux=%0d, want dac=%h sample=%b busy=%b done=%b mux=%0d",
                 d, c, dac_v[d], smp_v[d], busy_v[d], done_v[d], mux_v[d], ed, es, eb, edn, ch);
      end
      er  = edn ? expres : prev_res[d];
      erc = edn ? ch : prev_ch[d];
      n_chk++;
      if (res_v[d] !== er || rc_v[d] !== 2'(erc)) begin
        n_fail++;
        $display("FAIL result dut%0d cyc%0d: result=%h ch=%0d, want result=%h ch=%0d", d, c, res_v[d], rc_v[d], er, erc);
      end
      if (c < t) tick();
    end
    prev_res[d] = expres;
    prev_ch[d]  = ch;
  endtask

  task automatic check_idle(input int d, input string tag);
    n_chk++;
    if (busy_v[d] !== 1'b0 || smp_v[d] !== 1'b0 || done_v[d] !== 1'b0 || dac_v[d] !== 16'h0) begin
      n_fail++;
      $display("FAIL %s dut%0d: busy=%b sample=%b done=%b dac=%h, want all 0", tag, d, busy_v[d], smp_v[d], done_v[d], dac_v[d]);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int d = 0; d < 3; d++) begin
      start_v[d] = 0; scan_v[d] = 0; chs_v[d] = 0; cmode[d] = 2; vin[d] = 0;
      prev_res[d] = 0; prev_ch[d] = 0;
    end
    #12;
    for (int d = 0; d < 3; d++) begin
      n_chk++;
      if (dac_v[d] !== 0 || res_v[d] !== 0 || mux_v[d] !== 0 || rc_v[d] !== 0 ||
          smp_v[d] !== 0 || busy_v[d] !== 0 || done_v[d] !== 0) begin
        n_fail++;
        $display("FAIL reset dut%0d: dac=%h res=%h mux=%0d rch=%0d smp=%b busy=%b done=%b, want all 0",
                 d, dac_v[d], res_v[d], mux_v[d], rc_v[d], smp_v[d], busy_v[d], done_v[d]);
      end
    end
    tick();
    reset = 1'b1;
    tick();
    for (int d = 0; d < 3; d++) check_idle(d, "post_reset");
  endtask

  task automatic test_directed();
    cmode[0] = 2; vin[0] = 16'hA5C;
    begin_conv(0, 2);
    walk_conv(0, 2, 0, 0);
    tick();
    check_idle(0, "directed_end");
  endtask

  task automatic test_rails();
    for (int k = 0; k < 4; k++) begin
      int d;
      d = (k < 2) ? 0 : 2;
      cmode[d] = (k % 2 == 0) ? 1 : 0;
      begin_conv(d, k);
      walk_conv(d, k, 0, 0);
      tick();
    end
  endtask

  task automatic test_scan();
    int exp_ch[5] = '{3, 0, 1, 2, 3};
    cmode[0] = 2; vin[0] = 16'($urandom_range(0, 4095));
    scan_v[0] = 1'b1;
    begin_conv(0, 3);
    for (int k = 0; k < 5; k++) begin
      walk_conv(0, exp_ch[k], (k == 4) ? 7 : 0, 0);
      vin[0] = 16'($urandom_range(0, 4095));
      tick();
    end
    for (int k = 0; k < 4; k++) begin
      check_idle(0, "scan_stop");
      tick();
    end
  endtask

  task automatic test_reset_mid();
    cmode[0] = 2; vin[0] = 16'($urandom_range(0, 4095));
    begin_conv(0, 1);
    for (int k = 0; k < 7; k++) tick();
    reset = 1'b0;
    #1;
    n_chk++;
    if (dac_v[0] !== 0 || res_v[0] !== 0 || mux_v[0] !== 0 || rc_v[0] !== 0 ||
        smp_v[0] !== 0 || busy_v[0] !== 0 || done_v[0] !== 0) begin
      n_fail++;
      $display("FAIL reset_mid: dac=%h res=%h mux=%0d rch=%0d smp=%b busy=%b done=%b, want all 0",
               dac_v[0], res_v[0], mux_v[0], rc_v[0], smp_v[0], busy_v[0], done_v[0]);
    end
    for (int d = 0; d < 3; d++) begin
      prev_res[d] = 0; prev_ch[d] = 0;
    end
    tick();
    reset = 1'b1;
    for (int k = 0; k < 16; k++) begin
      tick();
      check_idle(0, "reset_mid_quiet");
    end
    vin[0] = 16'($urandom_range(0, 4095));
    begin_conv(0, 2);
    walk_conv(0, 2, 0, 0);
    tick();
  endtask

  task automatic test_settle3();
    cmode[1] = 2; vin[1] = 16'($urandom_range(0, 4095));
    begin_conv(1, 1);
    walk_conv(1, 1, 0, 0);
    tick();
    check_idle(1, "settle3_end");
  endtask

  task automatic test_start_ignored();
    cmode[1] = 2; vin[1] = 16'($urandom_range(0, 4095));
    begin_conv(1, 0);
    walk_conv(1, 0, 0, 1);
    tick();
    start_v[1] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check_idle(1, "start_ignored");
      tick();
    end
  endtask

  task automatic test_ch_range();
    cmode[1] = 2; vin[1] = 16'($urandom_range(0, 4095));
    begin_conv(1, 3);
    walk_conv(1, 0, 0, 0);
    tick();
  endtask

  task automatic test_random();
    for (int k = 0; k < 20; k++) begin
      int d, ch, ech;
      d  = $urandom_range(0, 2);
      ch = $urandom_range(0, 3);
      ech = (ch >= nch(d)) ? 0 : ch;
      cmode[d] = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 1) : 2;
      vin[d] = 16'($urandom_range(0, (1 << wid(d)) - 1));
      begin_conv(d, ch);
      walk_conv(d, ech, 0, 0);
      tick();
      check_idle(d, "random_end");
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_rails();
    test_scan();
    test_reset_mid();
    test_settle3();
    test_start_ignored();
    test_ch_range();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
